object_bbox_detect: RTL and testbench
=====================================

# object_bbox_detect

Per-frame bounding-box extractor for a binarised pixel stream. Scans each frame's foreground mask, tracks the min/max column and row of foreground pixels and the foreground pixel count. At the start of vertical blanking it publishes the box on rectangular_up/down/left/right plus flag. These outputs connect directly to the rectangle-overlay stage in the video_stitching object path.

## Interface
- IMG_HDISP, 11'd1024: active pixels per line; the column counter wraps here.
- IMG_VDISP, 11'd768: active lines per frame; the row counter saturates at IMG_VDISP-1.
- MIN_PIXELS, 20'd64: minimum foreground count for a frame to count as an object (noise reject).
- X_OFFSET, 11'd7: added to the reported left/right to pre-compensate the overlay's column alignment.

- clk  in  1  pixel clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- per_frame_vsync  in  1  high during vertical blanking.
- per_frame_href  in  1  line valid; informational only, not used for counting.
- per_frame_clken  in  1  pixel strobe; one active pixel per high cycle.
- per_img_bit  in  1  foreground mask, 1 = object pixel; qualified by clken.
- rectangular_up  out  11  min foreground row of the last accepted frame.
- rectangular_down  out  11  max foreground row.
- rectangular_left  out  11  min foreground column + X_OFFSET.
- rectangular_right  out  11  max foreground column + X_OFFSET.
- flag  out  1  last completed frame contained a valid object.
- frame_done  out  1  one-cycle pulse each time a frame result is latched.
- pixel_count  out  20  foreground count of the last completed frame.

## Operation
- x_cnt and y_cnt:
  - Both cleared while vsync is high.
  - On clken with vsync low: x_cnt increments. At IMG_HDISP-1, x_cnt wraps to 0 and y_cnt increments; y_cnt saturates at IMG_VDISP-1.
- Accumulators: min_x, max_x, min_y, max_y (11 b each) and cnt (20 b).
  - While vsync is high they are set to min_x = min_y = 11'h7FF, max_x = max_y = 0, cnt = 0.
  - On clken & per_img_bit & !vsync: min_x = min(min_x, x_cnt), max_x = max(max_x, x_cnt), min_y = min(min_y, y_cnt), max_y = max(max_y, y_cnt).
  - cnt increments and saturates at 20'hFFFFF.
- armed bit:
  - Cleared by reset.
  - Set on a vsync falling edge, i.e. the first full frame begins.
  - Only an armed frame may publish a result. This guarantees a frame cut by reset mid-stream is never reported.
- Frame end, on a vsync rising edge (vsync=1, vsync_d=0) with armed=1. Using the accumulator values from before the clear:
  - pixel_count <= cnt; frame_done pulses.
  - If cnt >= MIN_PIXELS: flag <= 1, up <= min_y, down <= max_y, left <= min_x + X_OFFSET, right <= max_x + X_OFFSET. The 11-bit additions wrap modulo 2048 with no clamp.
  - Otherwise: flag <= 0 and the four coordinates hold their previous values.
- A vsync rising edge while unarmed produces no frame_done, and outputs are unchanged.
- clken pulses while vsync is high are ignored.
- Reset values: all coordinates 0, flag 0, frame_done 0, pixel_count 0, armed 0, vsync_d 0. Counters and accumulators take their vsync-high values.

## Timing
- Accumulator update: registered on the same edge that samples the qualifying clken pixel.
- Result latency: result registers load on the edge that first samples vsync=1 with vsync_d=0. The new values and frame_done are visible in the cycle after that edge.
- Accumulator clear:
  - A pixel sampled in the cycle before vsync rises is included in the result.
  - The edge that samples vsync=1 commits the result from the old accumulators and simultaneously clears them (same edge).
- Stability: coordinates and flag stay stable for the whole following frame, so the overlay sees constant values.
- Back-to-back frames: the minimum vsync-high width is 1 cycle; the design must be correct at that width.
- Reset mid-frame: outputs return to reset values on the next edge. No result is published until one full vsync low→high cycle has been observed.

## Test plan
1. Frame setup and object frame (reused by scenarios 2–4):
   - Params for all scenarios: IMG_HDISP=16, IMG_VDISP=8, MIN_PIXELS=4, X_OFFSET=7.
   - After reset, an initial vsync pulse arms the block; then one frame has foreground at rows 2–4, columns 3–6.
   - Expected at the end of that frame: up=2, down=4, left=10, right=13, flag=1, pixel_count=12, one frame_done pulse one cycle after vsync rises.
2. Next frame has only 3 foreground pixels -> flag=0, pixel_count=3, coordinates still 2/4/10/13.
3. Single-pixel extremes at (0,0) and (15,7) with MIN_PIXELS=2 -> up=0, down=7, left=7, right=22, flag=1.
4. Pulse rst high in the middle of a frame full of foreground; the next vsync rises -> no frame_done and flag=0. The following full frame then reports normally.
5. clken pulses with bit=1 while vsync is high, plus vsync-high width of 1 cycle between frames -> the blanking pulses are not counted. Each frame's box is independent and correct. Also check that a foreground pixel on the last clken before vsync rises is included.

Source files
------------

// File: rtl/object_bbox_detect.sv
// Per-frame bounding-box extractor for a binarised pixel stream.
// Publishes the foreground box, its pixel count and a validity flag at each vsync rise.
module object_bbox_detect #(
  parameter logic [10:0] IMG_HDISP  = 11'd1024,
  parameter logic [10:0] IMG_VDISP  = 11'd768,
  parameter logic [19:0] MIN_PIXELS = 20'd64,
  parameter logic [10:0] X_OFFSET   = 11'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic        per_img_bit,
  output logic [10:0] rectangular_up,
  output logic [10:0] rectangular_down,
  output logic [10:0] rectangular_left,
  output logic [10:0] rectangular_right,
  output logic        flag,
  output logic        frame_done,
  output logic [19:0] pixel_count
);

  localparam logic [10:0] MinInit = 11'h7FF;

  logic [10:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [10:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [10:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic [19:0] cnt_q, cnt_d;
  logic        armed_q, armed_d, vsync_q;
  logic [10:0] up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
  logic        flag_q, flag_d, done_q, done_d;
  logic [19:0] pix_cnt_q, pix_cnt_d;
  logic        vs_rise, vs_fall, publish;
  logic        unused_href;

  // Line valid carries no information the pixel strobe does not already give.
  assign unused_href = per_frame_href;

  assign vs_rise = per_frame_vsync & ~vsync_q;
  assign vs_fall = ~per_frame_vsync & vsync_q;
  assign publish = vs_rise & armed_q;

  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    cnt_d   = cnt_q;
    if (per_frame_vsync) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
      min_x_d = MinInit;
      max_x_d = '0;
      min_y_d = MinInit;
      max_y_d = '0;
      cnt_d   = '0;
    end else if (per_frame_clken) begin
      if (x_cnt_q == IMG_HDISP - 11'd1) begin
        x_cnt_d = '0;
        if (y_cnt_q != IMG_VDISP - 11'd1) y_cnt_d = y_cnt_q + 11'd1;
      end else begin
        x_cnt_d = x_cnt_q + 11'd1;
      end
      if (per_img_bit) begin
        if (x_cnt_q < min_x_q) min_x_d = x_cnt_q;
        if (x_cnt_q > max_x_q) max_x_d = x_cnt_q;
        if (y_cnt_q < min_y_q) min_y_d = y_cnt_q;
        if (y_cnt_q > max_y_q) max_y_d = y_cnt_q;
        if (cnt_q != 20'hFFFFF) cnt_d = cnt_q + 20'd1;
      end
    end
  end

  // Result path reads the accumulators before the same-edge clear above.
  always_comb begin
    armed_d   = armed_q | vs_fall;
    done_d    = publish;
    pix_cnt_d = pix_cnt_q;
    flag_d    = flag_q;
    up_d      = up_q;
    down_d    = down_q;
    left_d    = left_q;
    right_d   = right_q;
    if (publish) begin
      pix_cnt_d = cnt_q;
      if (cnt_q >= MIN_PIXELS) begin
        flag_d  = 1'b1;
        up_d    = min_y_q;
        down_d  = max_y_q;
        left_d  = min_x_q + X_OFFSET;
        right_d = max_x_q + X_OFFSET;
      end else begin
        flag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt_q   <= '0;
      y_cnt_q   <= '0;
      min_x_q   <= MinInit;
      max_x_q   <= '0;
      min_y_q   <= MinInit;
      max_y_q   <= '0;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      vsync_q   <= 1'b0;
      up_q      <= '0;
      down_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      flag_q    <= 1'b0;
      done_q    <= 1'b0;
      pix_cnt_q <= '0;
    end else begin
      x_cnt_q   <= x_cnt_d;
      y_cnt_q   <= y_cnt_d;
      min_x_q   <= min_x_d;
      max_x_q   <= max_x_d;
      min_y_q   <= min_y_d;
      max_y_q   <= max_y_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      vsync_q   <= per_frame_vsync;
      up_q      <= up_d;
      down_q    <= down_d;
      left_q    <= left_d;
      right_q   <= right_d;
      flag_q    <= flag_d;
      done_q    <= done_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  assign rectangular_up    = up_q;
  assign rectangular_down  = down_q;
  assign rectangular_left  = left_q;
  assign rectangular_right = right_q;
  assign flag              = flag_q;
  assign frame_done        = done_q;
  assign pixel_count       = pix_cnt_q;

endmodule

// File: tb/tb_object_bbox_detect.sv
// Directed bench for object_bbox_detect: two instances (noise floor 4 and 2) share one stream,
// expected frame results are queued at each vsync rise and popped on frame_done.
module tb_object_bbox_detect;

  typedef struct packed {
    logic [10:0] up;
    logic [10:0] down;
    logic [10:0] left;
    logic [10:0] right;
    logic        flag;
    logic [19:0] cnt;
  } res_t;

  logic clk = 1'b0;
  logic rst, vsync, href, clken, pbit;
  logic [10:0] a_up, a_down, a_left, a_right, b_up, b_down, b_left, b_right;
  logic        a_flag, a_done, b_flag, b_done;
  logic [19:0] a_cnt, b_cnt;

  res_t qa[$];
  res_t qb[$];
  res_t ha, hb;
  logic mask [8][16];
  int   n_total = 0;
  int   n_pass = 0;
  bit   armed = 1'b0;
  bit   vs_prev = 1'b0;
  int   fr_cnt, fr_minx, fr_maxx, fr_miny, fr_maxy;

  always #5 clk = ~clk;

  object_bbox_detect #(
    .IMG_HDISP (11'd16),
    .IMG_VDISP (11'd8),
    .MIN_PIXELS(20'd4),
    .X_OFFSET  (11'd7)
  ) dut_a (
    .clk              (clk),
    .rst              (rst),
    .per_frame_vsync  (vsync),
    .per_frame_href   (href),
    .per_frame_clken  (clken),
    .per_img_bit      (pbit),
    .rectangular_up   (a_up),
    .rectangular_down (a_down),
    .rectangular_left (a_left),
    .rectangular_right(a_right),
    .flag             (a_flag),
    .frame_done       (a_done),
    .pixel_count      (a_cnt)
  );

  object_bbox_detect #(
    .IMG_HDISP (11'd16),
    .IMG_VDISP (11'd8),
    .MIN_PIXELS(20'd2),
    .X_OFFSET  (11'd7)
  ) dut_b (
    .clk              (clk),
    .rst              (rst),
    .per_frame_vsync  (vsync),
    .per_frame_href   (href),
    .per_frame_clken  (clken),
    .per_img_bit      (pbit),
    .rectangular_up   (b_up),
    .rectangular_down (b_down),
    .rectangular_left (b_left),
    .rectangular_right(b_right),
    .flag             (b_flag),
    .frame_done       (b_done),
    .pixel_count      (b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_res(input string nm, input res_t got, input res_t exp);
    chk({nm, ".up"}, 32'(got.up), 32'(exp.up));
    chk({nm, ".down"}, 32'(got.down), 32'(exp.down));
    chk({nm, ".left"}, 32'(got.left), 32'(exp.left));
    chk({nm, ".right"}, 32'(got.right), 32'(exp.right));
    chk({nm, ".flag"}, 32'(got.flag), 32'(exp.flag));
    chk({nm, ".pixel_count"}, 32'(got.cnt), 32'(exp.cnt));
  endtask

  function automatic res_t frame_result(input res_t held, input int min_pix);
    res_t r;
    r     = held;
    r.cnt = 20'(fr_cnt);
    if (fr_cnt >= min_pix) begin
      r.flag  = 1'b1;
      r.up    = 11'(fr_miny);
      r.down  = 11'(fr_maxy);
      r.left  = 11'(fr_minx + 7);
      r.right = 11'(fr_maxx + 7);
    end else begin
      r.flag = 1'b0;
    end
    return r;
  endfunction

  // One clock: drive, let the edge pass, update the model, compare both instances.
  task automatic step(input logic r, input logic vs, input logic ck, input logic b);
    bit   exp_done;
    res_t ga, gb;
    rst   = r;
    vsync = vs;
    clken = ck;
    href  = ck & ~vs;
    pbit  = b;
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    if (r) begin
      armed = 1'b0;
      ha    = '0;
      hb    = '0;
    end else begin
      if (vs && !vs_prev && armed) begin
        ha = frame_result(ha, 4);
        hb = frame_result(hb, 2);
        qa.push_back(ha);
        qb.push_back(hb);
        exp_done = 1'b1;
      end
      if (!vs && vs_prev) armed = 1'b1;
    end
    vs_prev = r ? 1'b0 : vs;
    ga = {a_up, a_down, a_left, a_right, a_flag, a_cnt};
    gb = {b_up, b_down, b_left, b_right, b_flag, b_cnt};
    chk("a.frame_done", 32'(a_done), 32'(exp_done));
    chk("b.frame_done", 32'(b_done), 32'(exp_done));
    if (a_done) begin
      chk("a.queue_has_entry", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) chk_res("a.result", ga, qa.pop_front());
    end
    if (b_done) begin
      chk("b.queue_has_entry", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) chk_res("b.result", gb, qb.pop_front());
    end
    chk_res("a.hold", ga, ha);
    chk_res("b.hold", gb, hb);
    @(negedge clk);
  endtask

  task automatic clear_mask();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) mask[r][c] = 1'b0;
  endtask

  task automatic set_rect(input int r0, input int r1, input int c0, input int c1);
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++) mask[r][c] = 1'b1;
  endtask

  // Raster one frame; idle strobe-low cycles (bit high) sit between lines but not after the last.
  task automatic run_frame(input int rst_row);
    fr_cnt  = 0;
    fr_minx = 2047;
    fr_maxx = 0;
    fr_miny = 2047;
    fr_maxy = 0;
    for (int r = 0; r < 8; r++) begin
      if (r == rst_row) step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 16; c++) begin
        step(1'b0, 1'b0, 1'b1, mask[r][c]);
        if (mask[r][c]) begin
          fr_cnt++;
          if (c < fr_minx) fr_minx = c;
          if (c > fr_maxx) fr_maxx = c;
          if (r < fr_miny) fr_miny = r;
          if (r > fr_maxy) fr_maxy = r;
        end
      end
      if (r < 7) step(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  // Blanking with foreground strobes that must be ignored.
  task automatic blank(input int width);
    for (int i = 0; i < width; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    ha = '0;
    hb = '0;
    rst = 1'b1; vsync = 1'b0; href = 1'b0; clken = 1'b0; pbit = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    blank(2);                            // unarmed rise: nothing published

    clear_mask(); set_rect(2, 4, 3, 6);  // box 2/4/10/13, 12 pixels
    run_frame(-1); blank(3);

    clear_mask();                        // 3 pixels: below floor for a, above for b
    mask[5][1] = 1'b1; mask[6][9] = 1'b1; mask[7][14] = 1'b1;
    run_frame(-1); blank(2);

    clear_mask();                        // corner extremes
    mask[0][0] = 1'b1; mask[7][15] = 1'b1;
    run_frame(-1); blank(1);

    clear_mask(); set_rect(0, 7, 0, 15); // reset mid-frame: never reported
    run_frame(3); blank(2);

    clear_mask(); set_rect(1, 6, 0, 15);
    run_frame(-1); blank(1);

    clear_mask();                        // last strobe before vsync is foreground
    mask[3][4] = 1'b1; mask[4][5] = 1'b1; mask[5][6] = 1'b1; mask[7][15] = 1'b1;
    run_frame(-1); blank(1);

    clear_mask(); set_rect(0, 0, 2, 5);
    run_frame(-1); blank(1);

    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("a.queue_drained", 32'(qa.size()), 32'd0);
    chk("b.queue_drained", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
